pipe_stage_skid_reg: RTL and testbench

- Next-generation inter-stage pipeline register for the CPU pipeline (D/E, E/M, M/W boundaries). Each stage boundary gets its own instance.
- Carries instr, pc, a parametrised payload bundle, the reg write-enable, the delay-slot flag and the exception code.
- Replaces the old freeze-only behaviour with a valid/ready handshake and a 2-entry skid buffer, so upstream ready is a pure register output.
- Adds a bubble-inserting flush and an exception-redirect flush with fixed priority.

---
 rtl/pipe_stage_skid_reg.sv | 183 ++++++++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a valid/ready handshake and a two-entry
// skid buffer. The upstream ready comes only from the state register. An
// exception redirect or a flush replaces the contents with a bubble.
//
// state | meaning
// ------+--------------------------------------------
// EMPTY | no entry held; out_valid low
// ONE   | main entry valid and driving the outputs
// TWO   | main and skid entries valid; in_ready low
module pipe_stage_skid_reg #(
    parameter int unsigned          INSTR_W  = 32,
    parameter int unsigned          PC_W     = 32,
    parameter int unsigned          DATA_W   = 96,
    parameter int unsigned          EXC_W    = 5,
    parameter logic [EXC_W-1:0]     EXC_NONE = 5'd31,
    parameter logic [PC_W-1:0]      PC_RESET = 32'h0000_3000,
    parameter logic [PC_W-1:0]      EXC_PC   = 32'h0000_4180
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [PC_W-1:0]     in_pc,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_regwe,
    input  logic                in_delay,
    input  logic [EXC_W-1:0]    in_exc,

    input  logic                out_ready,
    output logic                out_valid,
    output logic                out_bubble,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [PC_W-1:0]     out_pc,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_regwe,
    output logic                out_delay,
    output logic [EXC_W-1:0]    out_exc,

    input  logic                flush,
    input  logic                exc_req
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // One pipeline entry; the same layout is used for main and skid.
    typedef struct packed {
        logic               bubble;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [DATA_W-1:0]  data;
        logic               regwe;
        logic               delay;
        logic [EXC_W-1:0]   exc;
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q,  main_d;
    entry_t skid_q,  skid_d;

    entry_t in_entry;
    entry_t reset_entry;
    logic   accept;
    logic   drain;

    // Pack the upstream fields and the reset image of an entry.
    always_comb begin
        in_entry        = '0;
        in_entry.bubble = 1'b0;
        in_entry.instr  = in_instr;
        in_entry.pc     = in_pc;
        in_entry.data   = in_data;
        in_entry.regwe  = in_regwe;
        in_entry.delay  = in_delay;
        in_entry.exc    = in_exc;

        reset_entry        = '0;
        reset_entry.exc    = EXC_NONE;
        reset_entry.pc     = PC_RESET;
    end

    // Handshake terms; in_ready and out_valid are decoded from state_q only.
    always_comb begin
        accept = in_valid & in_ready;
        drain  = out_valid & out_ready;
    end

    // State and entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= reset_entry;
            skid_q  <= reset_entry;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next state and next entry contents: exc_req > flush > handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (exc_req) begin
            state_d       = ONE;
            skid_d        = reset_entry;
            main_d        = '0;
            main_d.bubble = 1'b1;
            main_d.exc    = EXC_NONE;
            main_d.pc     = EXC_PC;
            main_d.delay  = 1'b0;
        end else if (flush) begin
            // The bubble keeps the upstream pc/delay so the slot still
            // identifies where it sits in program order.
            state_d       = ONE;
            skid_d        = reset_entry;
            main_d        = '0;
            main_d.bubble = 1'b1;
            main_d.exc    = EXC_NONE;
            main_d.pc     = in_pc;
            main_d.delay  = in_delay;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_entry;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_entry;
                    end else if (drain) begin
                        // Going idle: scrub the fields that could be mistaken
                        // for a live instruction; pc and delay are kept.
                        state_d       = EMPTY;
                        main_d.bubble = 1'b0;
                        main_d.instr  = '0;
                        main_d.data   = '0;
                        main_d.regwe  = 1'b0;
                        main_d.exc    = EXC_NONE;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = reset_entry;
                    skid_d  = reset_entry;
                end
            endcase
        end
    end

    // Outputs: decoded from the state register and driven by the main entry.
    always_comb begin
        in_ready   = (state_q != TWO);
        out_valid  = (state_q != EMPTY);
        out_bubble = main_q.bubble;
        out_instr  = main_q.instr;
        out_pc     = main_q.pc;
        out_data   = main_q.data;
        out_regwe  = main_q.regwe;
        out_delay  = main_q.delay;
        out_exc    = main_q.exc;
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_instr;
    logic [31:0]  in_pc;
    logic [95:0]  in_data;
    logic         in_regwe;
    logic         in_delay;
    logic [4:0]   in_exc;
    logic         out_ready;
    logic         out_valid;
    logic         out_bubble;
    logic [31:0]  out_instr;
    logic [31:0]  out_pc;
    logic [95:0]  out_data;
    logic         out_regwe;
    logic         out_delay;
    logic [4:0]   out_exc;
    logic         flush;
    logic         exc_req;

    int tests_run;
    int tests_failed;

    pipe_stage_skid_reg dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_data    (in_data),
        .in_regwe   (in_regwe),
        .in_delay   (in_delay),
        .in_exc     (in_exc),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_bubble (out_bubble),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_data   (out_data),
        .out_regwe  (out_regwe),
        .out_delay  (out_delay),
        .out_exc    (out_exc),
        .flush      (flush),
        .exc_req    (exc_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        in_data   = '0;
        in_regwe  = 1'b0;
        in_delay  = 1'b0;
        in_exc    = 5'd31;
        out_ready = 1'b0;
        flush     = 1'b0;
        exc_req   = 1'b0;

        // Reset state
        step();
        step();
        check("rst_valid",  out_valid, 0);
        check("rst_bubble", out_bubble, 0);
        check("rst_ready",  in_ready, 1);
        check("rst_pc",     out_pc, 32'h3000);
        check("rst_exc",    out_exc, 31);
        check("rst_instr",  out_instr, 0);
        reset = 1'b0;

        // Single beat, one-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h3004;
        in_instr  = 32'h2401_0005;
        in_data   = 96'h1111_2222_3333_4444_5555_6666;
        in_regwe  = 1'b1;
        check("pre_load_exc", out_exc, 31);
        check("pre_load_valid", out_valid, 0);
        step();
        check("b1_valid", out_valid, 1);
        check("b1_pc",    out_pc, 32'h3004);
        check("b1_instr", out_instr, 32'h2401_0005);
        check("b1_data",  out_data, 96'h1111_2222_3333_4444_5555_6666);
        check("b1_regwe", out_regwe, 1);
        check("b1_ready", in_ready, 1);
        in_valid = 1'b0;
        step();
        check("b1_drain_valid", out_valid, 0);
        check("b1_drain_instr", out_instr, 0);
        check("b1_drain_regwe", out_regwe, 0);
        check("b1_drain_pc_kept", out_pc, 32'h3004);

        // Streaming at full throughput
        in_regwe = 1'b0;
        in_data  = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_pc    = 32'h3000 + 32'(4 * i);
            in_instr = 32'h100 + 32'(i);
            step();
            check("stream_valid", out_valid, 1);
            check("stream_pc", out_pc, 32'h3000 + 32'(4 * i));
            check("stream_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_end_valid", out_valid, 0);

        // Backpressure fills the skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h3000;
        step();
        check("bp1_pc", out_pc, 32'h3000);
        check("bp1_ready", in_ready, 1);
        in_pc = 32'h3004;
        step();
        check("bp2_ready", in_ready, 0);
        check("bp2_pc", out_pc, 32'h3000);
        in_pc = 32'h3008;
        step();
        check("bp3_ready", in_ready, 0);
        check("bp3_pc", out_pc, 32'h3000);
        out_ready = 1'b1;
        step();
        check("bp4_pc", out_pc, 32'h3004);
        check("bp4_ready", in_ready, 1);
        step();
        check("bp5_pc", out_pc, 32'h3008);
        check("bp5_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        check("bp6_valid", out_valid, 0);

        // Flush while holding two entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_regwe  = 1'b1;
        in_instr  = 32'hAAAA_0001;
        in_pc     = 32'h3020;
        step();
        in_pc = 32'h3024;
        step();
        check("fl_pre_ready", in_ready, 0);
        flush    = 1'b1;
        in_pc    = 32'h3010;
        in_delay = 1'b1;
        in_exc   = 5'd4;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_delay = 1'b0;
        in_exc   = 5'd31;
        check("fl_valid",  out_valid, 1);
        check("fl_bubble", out_bubble, 1);
        check("fl_instr",  out_instr, 0);
        check("fl_regwe",  out_regwe, 0);
        check("fl_pc",     out_pc, 32'h3010);
        check("fl_delay",  out_delay, 1);
        check("fl_exc",    out_exc, 31);
        check("fl_ready",  in_ready, 1);
        step();
        check("fl_hold_bubble", out_bubble, 1);
        check("fl_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        check("fl_skid_gone", out_valid, 0);
        check("fl_drain_bubble", out_bubble, 0);

        // exc_req beats flush; reset beats both
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h3030;
        step();
        in_valid = 1'b0;
        exc_req  = 1'b1;
        flush    = 1'b1;
        in_pc    = 32'h3010;
        in_delay = 1'b1;
        step();
        check("exc_pc",     out_pc, 32'h4180);
        check("exc_delay",  out_delay, 0);
        check("exc_bubble", out_bubble, 1);
        check("exc_valid",  out_valid, 1);
        reset = 1'b1;
        step();
        check("rst_exc_valid", out_valid, 0);
        check("rst_exc_pc", out_pc, 32'h3000);
        check("rst_exc_bubble", out_bubble, 0);
        reset    = 1'b0;
        exc_req  = 1'b0;
        flush    = 1'b0;
        in_delay = 1'b0;

        // Exception code passes through and is scrubbed on drain
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h3040;
        in_exc    = 5'd4;
        step();
        check("ex4_exc", out_exc, 4);
        check("ex4_pc", out_pc, 32'h3040);
        in_valid = 1'b0;
        in_exc   = 5'd31;
        step();
        check("ex4_drain_exc", out_exc, 31);
        check("ex4_drain_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
